// File: rtl/piece_dropper.sv
// piece_dropper: validates a column drop, animates the fall one row per FALL_TICKS cycles, then writes the board.
// Latency: turn_done 2 + (ROWS-target)*FALL_TICKS cycles after acceptance; requests while busy are silently dropped.
module piece_dropper #(
  parameter int COLS       = 7,
  parameter int ROWS       = 6,
  parameter int FALL_TICKS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   drop_req,
  input  logic [2:0]             drop_col,
  input  logic [1:0]             player,
  output logic                   busy,
  output logic                   turn_done,
  output logic                   drop_err,
  output logic                   anim_valid,
  output logic [2:0]             anim_row,
  output logic [2:0]             anim_col,
  output logic [2*COLS*ROWS-1:0] board,
  output logic                   board_full
);
  localparam int TW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
  // Height must be able to hold ROWS itself, which needs 4 bits when ROWS = 8.
  localparam int HW = $clog2(ROWS + 1);
  localparam int NB = 2*COLS*ROWS;

  typedef enum logic [1:0] {IDLE, FALL, PLACE, DONE} state_t;
  state_t state, state_nxt;

  logic [HW-1:0] height [COLS];
  logic [2:0]    col;
  logic [1:0]    pl;
  logic [2:0]    target;
  logic [2:0]    row;
  logic [TW-1:0] tick;
  logic          err;
  logic [NB-1:0] cells;

  logic [HW-1:0] sel_height;
  logic          col_ok, player_ok, req_ok, tick_last, full;

  always_comb begin
    sel_height = '0;
    for (int c = 0; c < COLS; c++)
      if (drop_col == 3'(c)) sel_height = height[c];
  end

  assign col_ok    = {1'b0, drop_col} < 4'(COLS);
  assign player_ok = (player == 2'b01) || (player == 2'b10);
  assign req_ok    = col_ok && player_ok && (sel_height < HW'(ROWS));
  assign tick_last = (tick == TW'(FALL_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (drop_req && req_ok) state_nxt = FALL;
      FALL:    if (tick_last && (row == target)) state_nxt = PLACE;
      PLACE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col    <= '0;
      pl     <= '0;
      target <= '0;
      row    <= '0;
      tick   <= '0;
      err    <= 1'b0;
      cells  <= '0;
      for (int c = 0; c < COLS; c++) height[c] <= '0;
    end else begin
      err <= (state == IDLE) && drop_req && !req_ok;
      case (state)
        IDLE: begin
          if (drop_req && req_ok) begin
            col    <= drop_col;
            pl     <= player;
            target <= 3'(sel_height);
            row    <= 3'(ROWS - 1);
            tick   <= '0;
          end
        end
        FALL: begin
          if (tick_last) begin
            tick <= '0;
            if (row != target) row <= row - 3'd1;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        PLACE: begin
          cells[2*(int'(target)*COLS + int'(col)) +: 2] <= pl;
          for (int c = 0; c < COLS; c++)
            if (col == 3'(c)) height[c] <= height[c] + HW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (height[c] != HW'(ROWS)) full = 1'b0;
  end

  assign busy       = (state != IDLE);
  assign turn_done  = (state == DONE);
  assign drop_err   = err;
  assign anim_valid = (state == FALL);
  assign anim_row   = row;
  assign anim_col   = col;
  assign board      = cells;
  assign board_full = full;
endmodule

// File: tb/tb_piece_dropper.sv
// Bench for piece_dropper: vector table, directed corner sequences and a randomized board fill against a board model.
module tb_piece_dropper;
  localparam int COLS       = 7;
  localparam int ROWS       = 6;
  localparam int FALL_TICKS = 4;
  localparam int NB         = 2*COLS*ROWS;

  logic          clk = 1'b0;
  logic          reset;
  logic          drop_req;
  logic [2:0]    drop_col;
  logic [1:0]    player;
  logic          busy, turn_done, drop_err, anim_valid, board_full;
  logic [2:0]    anim_row, anim_col;
  logic [NB-1:0] board;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] mboard [ROWS][COLS];
  int         mh [8];

  always #5 clk = ~clk;

  piece_dropper #(.COLS(COLS), .ROWS(ROWS), .FALL_TICKS(FALL_TICKS)) dut (
    .clk(clk), .reset(reset), .drop_req(drop_req), .drop_col(drop_col), .player(player),
    .busy(busy), .turn_done(turn_done), .drop_err(drop_err), .anim_valid(anim_valid),
    .anim_row(anim_row), .anim_col(anim_col), .board(board), .board_full(board_full)
  );

  typedef struct {
    logic [2:0] col;
    logic [1:0] pl;
    bit         err;
    int         row;
  } vec_t;
  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mboard[r][c] = 2'b00;
    for (int c = 0; c < 8; c++) mh[c] = 0;
  endfunction

  function automatic logic [NB-1:0] image();
    logic [NB-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[2*(r*COLS+c) +: 2] = mboard[r][c];
    return v;
  endfunction

  function automatic bit model_full();
    bit f;
    f = 1'b1;
    for (int c = 0; c < COLS; c++) if (mh[c] != ROWS) f = 1'b0;
    return f;
  endfunction

  // Issues one request from IDLE and follows it until the DUT is back in IDLE.
  task automatic drop(input logic [2:0] c, input logic [1:0] p, input bit disturb,
                      output bit got_err, output int got_row);
    bit ok;
    int tgt, fall;
    ok = (int'(c) < COLS) && (p == 2'b01 || p == 2'b10) && (mh[c] < ROWS);
    drop_req = 1'b1;
    drop_col = c;
    player   = p;
    step();
    drop_req = 1'b0;
    got_err  = drop_err;
    got_row  = -1;
    if (!ok) begin
      check("err_pulse", drop_err, 1);
      check("err_idle", busy, 0);
      step();
      check("err_once", drop_err, 0);
      check("err_board", board, image());
      check("err_no_done", turn_done, 0);
      check("err_busy", busy, 0);
    end else begin
      tgt  = mh[c];
      fall = (ROWS - tgt) * FALL_TICKS;
      check("acc_no_err", drop_err, 0);
      for (int i = 0; i < fall; i++) begin
        if (i > 0) step();
        check("fall_valid", anim_valid, 1);
        check("fall_busy", busy, 1);
        check("fall_row", anim_row, ROWS - 1 - i / FALL_TICKS);
        check("fall_col", anim_col, c);
        check("fall_no_done", turn_done, 0);
        check("fall_no_err", drop_err, 0);
        got_row = int'(anim_row);
        if (disturb && i == 2) begin
          drop_req = 1'b1;
          drop_col = 3'd5;
          player   = ~p;
        end
        if (i == 3) drop_req = 1'b0;
      end
      step();
      check("place_busy", busy, 1);
      check("place_no_anim", anim_valid, 0);
      check("place_no_done", turn_done, 0);
      step();
      mboard[tgt][c] = p;
      mh[c]++;
      check("done_pulse", turn_done, 1);
      check("done_board", board, image());
      check("done_full", board_full, model_full());
      step();
      check("done_once", turn_done, 0);
      check("idle_busy", busy, 0);
      check("idle_err", drop_err, 0);
    end
  endtask

  initial begin
    bit e, seen;
    int rw, r;

    vecs[0]  = '{3'd0, 2'b01, 1'b0, 0};
    vecs[1]  = '{3'd0, 2'b10, 1'b0, 1};
    vecs[2]  = '{3'd0, 2'b01, 1'b0, 2};
    vecs[3]  = '{3'd0, 2'b10, 1'b0, 3};
    vecs[4]  = '{3'd0, 2'b01, 1'b0, 4};
    vecs[5]  = '{3'd0, 2'b10, 1'b0, 5};
    vecs[6]  = '{3'd0, 2'b01, 1'b1, -1};
    vecs[7]  = '{3'd7, 2'b01, 1'b1, -1};
    vecs[8]  = '{3'd2, 2'b00, 1'b1, -1};
    vecs[9]  = '{3'd2, 2'b11, 1'b1, -1};
    vecs[10] = '{3'd2, 2'b10, 1'b0, 0};

    model_reset();
    reset    = 1'b1;
    drop_req = 1'b0;
    drop_col = 3'd0;
    player   = 2'b00;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", turn_done, 0);
    check("rst_err", drop_err, 0);
    check("rst_anim", anim_valid, 0);
    check("rst_row", anim_row, 0);
    check("rst_col", anim_col, 0);
    check("rst_board", board, 0);
    check("rst_full", board_full, 0);
    reset = 1'b0;
    step();

    drop(3'd3, 2'b01, 1'b0, e, rw);
    check("t1_row", rw, 0);
    check("t1_cell", board[7:6], 2'b01);
    drop(3'd3, 2'b10, 1'b0, e, rw);
    check("t2_row", rw, 1);
    check("t2_cell", board[21:20], 2'b10);
    check("t2_keep", board[7:6], 2'b01);

    for (int i = 0; i < 11; i++) begin
      drop(vecs[i].col, vecs[i].pl, 1'b0, e, rw);
      check("vec_err", e, vecs[i].err);
      if (!vecs[i].err) check("vec_row", rw, vecs[i].row);
    end

    drop(3'd1, 2'b01, 1'b1, e, rw);
    check("t5_cell", board[3:2], 2'b01);
    check("t5_col5", board[11:10], 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (turn_done || drop_err || busy) seen = 1'b1;
    end
    check("t5_quiet", seen, 0);

    drop_req = 1'b1;
    drop_col = 3'd4;
    player   = 2'b10;
    step();
    drop_req = 1'b0;
    repeat (9) step();
    check("t6_in_fall", anim_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check("t6_board", board, 0);
    check("t6_busy", busy, 0);
    check("t6_anim", anim_valid, 0);
    check("t6_row", anim_row, 0);
    check("t6_col", anim_col, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (turn_done) seen = 1'b1;
    end
    check("t6_no_done", seen, 0);

    for (int it = 0; it < 400 && !model_full(); it++) begin
      r = $urandom_range(0, 7);
      if (r == 0)
        drop(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0, e, rw);
      else
        drop(3'($urandom_range(0, COLS - 1)), 2'($urandom_range(1, 2)),
             ($urandom_range(0, 3) == 0), e, rw);
    end
    check("fill_full", board_full, 1);
    check("fill_board", board, image());
    drop(3'd2, 2'b01, 1'b0, e, rw);
    check("full_reject", e, 1);
    drop(3'd6, 2'b10, 1'b0, e, rw);
    check("full_reject2", e, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
